// File: rtl/spi_pkg.sv
// Shared SPI link definitions: master FSM states, frame format constants and
// a small elaboration-time helper used to size the phase counter.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;
  localparam logic        SPI_CPOL   = 1'b0;
  localparam logic        SPI_CPHA   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_DONE
  } spi_mst_state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; o_tc is high on the last cycle of a loaded duration,
// so a load of N keeps the caller in its state for exactly N cycles.
module spi_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_count,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_count - W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI mode-0 master, MSB first. sclk, cs and mosi are registered
// so nothing on miso reaches an output combinationally.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SPI_DATA_W-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned     PH_W      = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
  localparam logic [PH_W-1:0] DIV_CNT   = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] SETUP_CNT = PH_W'(CS_SETUP);
  localparam logic [PH_W-1:0] HOLD_CNT  = PH_W'(CS_HOLD);
  localparam logic [3:0]      LAST_EDGE = 4'(SPI_DATA_W);
  localparam logic [2:0]      TOP_BIT   = 3'(SPI_DATA_W - 1);

  spi_mst_state_t r_state, w_state_nxt;

  logic                  w_tc;
  logic                  w_load;
  logic [PH_W-1:0]       w_load_val;
  logic                  w_accept;
  logic                  w_enter_high;
  logic                  w_enter_low;
  logic                  w_enter_done;

  logic [SPI_DATA_W-1:0] r_shift_tx;
  logic [SPI_DATA_W-1:0] r_shift_rx;
  logic [SPI_DATA_W-1:0] r_rx_data;
  logic [2:0]            r_bit_cnt;
  logic [3:0]            r_edge_cnt;
  logic                  r_cs;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;

  spi_phase_timer #(
    .W (PH_W)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_count (w_load_val),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Each transition reloads the shared timer with the duration of the state being entered.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_accept     = 1'b0;
    w_enter_high = 1'b0;
    w_enter_low  = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
          w_load_val  = SETUP_CNT;
        end
      end
      ST_SETUP: begin
        if (w_tc) begin
          w_state_nxt  = ST_HIGH;
          w_load       = 1'b1;
          w_load_val   = DIV_CNT;
          w_enter_high = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_tc) begin
          w_state_nxt = ST_LOW;
          w_load      = 1'b1;
          w_load_val  = DIV_CNT;
          w_enter_low = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_tc) begin
          w_load = 1'b1;
          if (r_edge_cnt == LAST_EDGE) begin
            w_state_nxt = ST_HOLD;
            w_load_val  = HOLD_CNT;
          end else begin
            w_state_nxt  = ST_HIGH;
            w_load_val   = DIV_CNT;
            w_enter_high = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_tc) begin
          w_state_nxt  = ST_DONE;
          w_enter_done = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs       <= 1'b1;
      r_sclk     <= SPI_CPOL;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rx_data  <= '0;
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_bit_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift_tx <= tx_data;
        r_bit_cnt  <= TOP_BIT;
        r_edge_cnt <= '0;
        r_mosi     <= tx_data[SPI_DATA_W-1];
        r_cs       <= 1'b0;
        r_busy     <= 1'b1;
      end
      if (w_enter_high) begin
        r_sclk                <= ~SPI_CPOL;
        r_shift_rx[r_bit_cnt] <= miso;
      end
      // mosi advances on the falling edge; after bit 0 it simply holds.
      if (w_enter_low) begin
        r_sclk     <= SPI_CPOL;
        r_edge_cnt <= r_edge_cnt + 4'd1;
        if (r_bit_cnt != '0) begin
          r_bit_cnt <= r_bit_cnt - 3'd1;
          r_mosi    <= r_shift_tx[r_bit_cnt - 3'd1];
        end
      end
      if (w_enter_done) begin
        r_cs      <= 1'b1;
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
        r_rx_data <= r_shift_rx;
      end
    end
  end

  assign cs      = r_cs;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule
